spi_master: RTL and testbench
=============================

# spi_master

Transaction-level SPI master, the initiator side of the SPI slave + single-port RAM subsystem. It accepts a 10-bit command word from a host, serialises it onto `SS_n`/`MOSI` using the codebase's framing, which is clocked on the system clock. For read-data commands it deserialises the 8-bit RAM word returned on `MISO` and presents it to the host. It sits between a host/bus adapter and the SPI slave, and is the stimulus engine used for system-level tests of the slave/RAM pair.

## Interface
- `MISO_DLY`, default 3: wait cycles between the last MOSI bit and the first MISO sample (range 1–15).
- `clk` in 1: system clock; all logic on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: request a frame; accepted only when `busy`=0.
- `cmd_word` in 10: `[9:8]` command (00 write addr, 01 write data, 10 read addr, 11 read data), `[7:0]` payload; latched on acceptance.
- `busy` out 1: a frame is in progress.
- `done` out 1: one-cycle pulse at frame end.
- `rd_data` out 8: last word received on MISO; holds until the next read-data frame.
- `rd_valid` out 1: one-cycle pulse, coincident with `done`, after a read-data frame.
- `seq_err` out 1: one-cycle pulse; see Configuration.
- `SS_n` out 1: slave select, active-low, registered.
- `MOSI` out 1: serial data to the slave, registered.
- `MISO` in 1: serial data from the slave.

## Operation
- FSM states: IDLE, START, CMD, SHIFT, TAIL, WAIT, RECV, END.
- IDLE: `SS_n`=1, `MOSI`=0. `start`=1 latches `cmd_word`, sets `busy`, and moves to START.
- START: `SS_n`=0, `MOSI`=0 for 1 cycle. This is the slave's IDLE→CHK_CMD cycle.
- CMD: `MOSI`=`cmd[9]` for 1 cycle. This is the slave's command-bit sample.
- SHIFT: 10 cycles, MSB first, `MOSI`=`cmd[9]` … `cmd[0]`. A 4-bit down-counter is loaded with 10.
- After SHIFT, commands 00/01/10 go to TAIL. TAIL holds `SS_n`=0 and `MOSI`=0 for 1 cycle so the slave reaches counter 0 and asserts `rx_valid`.
- After SHIFT, command 11 goes to WAIT for `MISO_DLY` cycles, then RECV.
- RECV: 8 cycles. `MISO` is shifted into an 8-bit register, MSB first.
- END: `SS_n`=1, `MOSI`=0, `done`=1, `busy`=0. For command 11, `rd_data` is loaded and `rd_valid`=1. Next state is IDLE.
- Because `busy`=0 in END, `start` is accepted in END. That gives one `SS_n`-high cycle between frames, which the slave requires as its minimum.
- `start` is ignored while `busy`=1. Changes to `cmd_word` after acceptance have no effect.

## Timing
- Cycle index k: k=0 is the first cycle with `SS_n`=0, and is the cycle after `start` is accepted.
- Write / read-addr frames: CMD at k=1, SHIFT at k=2..11 (bit 9 at k=2, bit 0 at k=11), TAIL at k=12, END at k=13. `SS_n` is low for 13 cycles.
- Read-data frames: WAIT at k=12..11+`MISO_DLY`, RECV at k=12+`MISO_DLY`..19+`MISO_DLY`, END at k=20+`MISO_DLY`.
- With the default `MISO_DLY`=3, the first MISO sample is taken at the close of k=15. This matches slave `rx_valid`, then RAM `tx_valid` one cycle later, then a registered MISO.
- Reset (`rst_n`=0 at an edge), including mid-frame: next cycle `SS_n`=1, `MOSI`=0, `busy`=0, `done`=0, `rd_valid`=0, `seq_err`=0, `rd_data`=0, state IDLE, read-address flag cleared.
- A frame aborted by reset produces no `done` pulse.

## Configuration
- Macro `SPI_MASTER_SEQ_CHK_EN`.
- When defined:
  - A read-address-loaded flag is set at END of a command-10 frame and cleared at END of a command-11 frame.
  - A command-11 `start` while the flag is clear produces no frame: `SS_n` stays 1, and `seq_err` and `done` pulse together in the cycle after acceptance.
- When undefined: no flag, `seq_err` tied 0, every command issued unchanged.

## Structure
- Add to `SPI_slave_shared_pkg`:
  - `SPI_master_state_e` enum.
  - Command constants `CMD_WR_ADDR`=2'b00, `CMD_WR_DATA`=2'b01, `CMD_RD_ADDR`=2'b10, `CMD_RD_DATA`=2'b11.
  - Frame length constants: 10 shift bits, 8 receive bits.
- No sub-module. The shift and receive registers are inline; a single FSM with one down-counter is sufficient.

## Test plan
- Write addr: `start` with `cmd_word`=10'h0A5 → MOSI bits k=1..11 are 0,0,0,1,0,1,0,0,1,0,1; `SS_n` low k=0..12; `done` at k=13; `rd_valid`=0.
- Write data then read addr 10'h2A5 against the slave+RAM → slave `rx_data`=10'h2A5 with `rx_valid`; `done` at k=13.
- Read data 10'h300 with the slave driving MISO 8'hC3 → `rd_data`=8'hC3 and `rd_valid`+`done` at k=23; `SS_n` low k=0..22.
- Back-to-back: `start` held high → second frame's `SS_n` falls exactly 1 cycle after the first `done`; `start` pulses while `busy` are ignored.
- Reset at k=6 of a write frame → `SS_n`=1, `busy`=0 next cycle, no `done`; a following frame completes normally.
- With `SPI_MASTER_SEQ_CHK_EN`: command 11 with no prior command 10 → `seq_err`+`done` one cycle after `start`, `SS_n` never low. Without the macro, the frame is issued and `seq_err` stays 0.

Source files
------------

// File: rtl/SPI_slave_shared_pkg.sv
// Shared types and constants for the SPI slave/RAM subsystem and its master.
// Holds the master FSM state enum, command codes and frame lengths.
package SPI_slave_shared_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        CMD,
        SHIFT,
        TAIL,
        WAIT,
        RECV,
        END
    } SPI_master_state_e;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    localparam logic [3:0] SHIFT_BITS = 4'd10;
    localparam logic [3:0] RECV_BITS  = 4'd8;

endpackage

// File: rtl/spi_master.sv
// Transaction-level SPI master: serialises a 10-bit command on SS_n/MOSI,
// clocked on clk, and for read-data commands captures 8 bits from MISO.
// Ports: clk, rst_n (sync, active-low), start, cmd_word[9:0] -> busy, done,
//        rd_data[7:0], rd_valid, seq_err; SS_n, MOSI out, MISO in.
// Param MISO_DLY (1..15): wait cycles between last MOSI bit and first sample.
// Optional macro SPI_MASTER_SEQ_CHK_EN: reject read-data without a prior
// read-address frame (seq_err + done, no frame on the wire).
module spi_master #(
    parameter int MISO_DLY = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [9:0] cmd_word,
    output logic       busy,
    output logic       done,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       seq_err,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
);
    import SPI_slave_shared_pkg::*;

    localparam logic [3:0] DLY = MISO_DLY[3:0];

    SPI_master_state_e state;
    logic [9:0] cmd_q;
    logic [9:0] sh;
    logic [7:0] rx;
    logic [3:0] cnt;
    logic       accept;

`ifdef SPI_MASTER_SEQ_CHK_EN
    logic rd_addr_ok;
`endif

    // END drops busy, so a new frame can be taken there as well as in IDLE.
    assign accept = start && (state == IDLE || state == END);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            SS_n     <= 1'b1;
            MOSI     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rd_valid <= 1'b0;
            seq_err  <= 1'b0;
            rd_data  <= 8'h00;
            cmd_q    <= 10'h000;
            sh       <= 10'h000;
            rx       <= 8'h00;
            cnt      <= 4'd0;
`ifdef SPI_MASTER_SEQ_CHK_EN
            rd_addr_ok <= 1'b0;
`endif
        end else begin
            done     <= 1'b0;
            rd_valid <= 1'b0;
            seq_err  <= 1'b0;
            if (accept) begin
                cmd_q <= cmd_word;
                sh    <= cmd_word;
`ifdef SPI_MASTER_SEQ_CHK_EN
                if (cmd_word[9:8] == CMD_RD_DATA && !rd_addr_ok) begin
                    // Rejected: stay off the wire, report in one cycle.
                    state   <= END;
                    done    <= 1'b1;
                    seq_err <= 1'b1;
                end else begin
                    state <= START;
                    SS_n  <= 1'b0;
                    MOSI  <= 1'b0;
                    busy  <= 1'b1;
                end
`else
                state <= START;
                SS_n  <= 1'b0;
                MOSI  <= 1'b0;
                busy  <= 1'b1;
`endif
            end else begin
                unique case (state)
                    IDLE: begin
                        SS_n <= 1'b1;
                        MOSI <= 1'b0;
                    end
                    START: begin
                        state <= CMD;
                        MOSI  <= sh[9];
                    end
                    CMD: begin
                        // Bit 9 is repeated: first as the command-bit
                        // sample, then as the first shifted bit.
                        state <= SHIFT;
                        MOSI  <= sh[9];
                        cnt   <= SHIFT_BITS;
                    end
                    SHIFT: begin
                        cnt  <= cnt - 4'd1;
                        MOSI <= sh[8];
                        sh   <= {sh[8:0], 1'b0};
                        if (cnt == 4'd1) begin
                            MOSI <= 1'b0;
                            if (cmd_q[9:8] == CMD_RD_DATA) begin
                                state <= WAIT;
                                cnt   <= DLY;
                            end else begin
                                state <= TAIL;
                            end
                        end
                    end
                    TAIL: begin
                        state <= END;
                        SS_n  <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
`ifdef SPI_MASTER_SEQ_CHK_EN
                        if (cmd_q[9:8] == CMD_RD_ADDR)
                            rd_addr_ok <= 1'b1;
`endif
                    end
                    WAIT: begin
                        cnt <= cnt - 4'd1;
                        if (cnt == 4'd1) begin
                            state <= RECV;
                            cnt   <= RECV_BITS;
                        end
                    end
                    RECV: begin
                        rx  <= {rx[6:0], MISO};
                        cnt <= cnt - 4'd1;
                        if (cnt == 4'd1) begin
                            state    <= END;
                            SS_n     <= 1'b1;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            rd_valid <= 1'b1;
                            rd_data  <= {rx[6:0], MISO};
`ifdef SPI_MASTER_SEQ_CHK_EN
                            rd_addr_ok <= 1'b0;
`endif
                        end
                    end
                    END: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                        SS_n  <= 1'b1;
                        MOSI  <= 1'b0;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master with directed command frames.
// Covers reset, write/read-addr/read-data frames, back-to-back, mid-frame reset.
module tb_spi_master;

    localparam int D     = 3;
    localparam int FIRST = 12 + D;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [9:0] cmd_word = 10'h000;
    logic       busy;
    logic       done;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       seq_err;
    logic       SS_n;
    logic       MOSI;
    logic       MISO = 1'b0;

    int tests = 0;
    int fails = 0;

    logic       ss_a   [0:39];
    logic       mosi_a [0:39];
    logic       done_a [0:39];
    logic       rv_a   [0:39];
    logic       busy_a [0:39];
    logic       se_a   [0:39];
    logic [7:0] rdd_a  [0:39];

    spi_master #(.MISO_DLY(D)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .cmd_word(cmd_word),
        .busy(busy),
        .done(done),
        .rd_data(rd_data),
        .rd_valid(rd_valid),
        .seq_err(seq_err),
        .SS_n(SS_n),
        .MOSI(MOSI),
        .MISO(MISO)
    );

    always #5 clk = ~clk;

    // Runs n cycles from k=0, keeping start high while k < hold_k,
    // switching cmd_word to cmd2 at k=2 and driving mbyte on MISO.
    task automatic capture(input logic [9:0] cmd, input int n,
                           input logic [7:0] mbyte, input int hold_k,
                           input logic [9:0] cmd2);
        @(negedge clk);
        start = 1'b1;
        cmd_word = cmd;
        @(posedge clk);
        #1;
        for (int k = 0; k < n; k++) begin
            start = (k < hold_k);
            if (k == 2) cmd_word = cmd2;
            if (k >= FIRST && k < FIRST + 8)
                MISO = mbyte[7 - (k - FIRST)];
            else
                MISO = 1'b0;
            ss_a[k]   = SS_n;
            mosi_a[k] = MOSI;
            done_a[k] = done;
            rv_a[k]   = rd_valid;
            busy_a[k] = busy;
            se_a[k]   = seq_err;
            rdd_a[k]  = rd_data;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        MISO = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({SS_n, MOSI, busy, done, rd_valid, seq_err} !== 6'b100000) begin
            fails++;
            $display("FAIL reset_ctl got=%b want=100000",
                     {SS_n, MOSI, busy, done, rd_valid, seq_err});
        end
        tests++;
        if (rd_data !== 8'h00) begin
            fails++;
            $display("FAIL reset_rd_data got=%h want=00", rd_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_seq_check();
`ifdef SPI_MASTER_SEQ_CHK_EN
        @(negedge clk);
        start = 1'b1;
        cmd_word = 10'h300;
        @(posedge clk);
        #1;
        start = 1'b0;
        tests++;
        if ({seq_err, done, SS_n, busy} !== 4'b1110) begin
            fails++;
            $display("FAIL seq_err_pulse got=%b want=1110",
                     {seq_err, done, SS_n, busy});
        end
        @(posedge clk);
        #1;
        tests++;
        if ({seq_err, done, SS_n} !== 3'b001) begin
            fails++;
            $display("FAIL seq_err_after got=%b want=001",
                     {seq_err, done, SS_n});
        end
`else
        int se_cnt;
        capture(10'h300, 24, 8'h5A, 0, 10'h300);
        se_cnt = 0;
        for (int k = 0; k < 24; k++) if (se_a[k] === 1'b1) se_cnt++;
        tests++;
        if (ss_a[0] !== 1'b0 || se_cnt != 0) begin
            fails++;
            $display("FAIL seq_off_issue ss0=%b seq_cnt=%0d want ss0=0 cnt=0",
                     ss_a[0], se_cnt);
        end
        tests++;
        if (done_a[23] !== 1'b1 || rdd_a[23] !== 8'h5A) begin
            fails++;
            $display("FAIL seq_off_read done=%b data=%h want 1 5a",
                     done_a[23], rdd_a[23]);
        end
`endif
    endtask

    task automatic test_write_addr();
        logic [10:0] exp_bits;
        logic [10:0] got_bits;
        int done_cnt;
        int rv_cnt;
        int ss_bad;
        exp_bits = 11'b000_1010_0101;
        capture(10'h0A5, 16, 8'h00, 0, 10'h0A5);
        for (int k = 1; k <= 11; k++) got_bits[11 - k] = mosi_a[k];
        tests++;
        if (got_bits !== exp_bits) begin
            fails++;
            $display("FAIL wa_mosi got=%b want=%b", got_bits, exp_bits);
        end
        tests++;
        if (mosi_a[0] !== 1'b0 || mosi_a[12] !== 1'b0) begin
            fails++;
            $display("FAIL wa_mosi_edges k0=%b k12=%b want 0 0",
                     mosi_a[0], mosi_a[12]);
        end
        ss_bad = 0;
        for (int k = 0; k <= 12; k++) if (ss_a[k] !== 1'b0) ss_bad++;
        tests++;
        if (ss_bad != 0 || ss_a[13] !== 1'b1) begin
            fails++;
            $display("FAIL wa_ss high_in_frame=%0d k13=%b want 0 1",
                     ss_bad, ss_a[13]);
        end
        done_cnt = 0;
        rv_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            if (done_a[k] === 1'b1) done_cnt++;
            if (rv_a[k] === 1'b1) rv_cnt++;
        end
        tests++;
        if (done_a[13] !== 1'b1 || done_cnt != 1 || rv_cnt != 0) begin
            fails++;
            $display("FAIL wa_done k13=%b cnt=%0d rv=%0d want 1 1 0",
                     done_a[13], done_cnt, rv_cnt);
        end
        tests++;
        if (busy_a[0] !== 1'b1 || busy_a[12] !== 1'b1 || busy_a[13] !== 1'b0) begin
            fails++;
            $display("FAIL wa_busy k0=%b k12=%b k13=%b want 1 1 0",
                     busy_a[0], busy_a[12], busy_a[13]);
        end
    endtask

    task automatic test_write_rd_addr();
        logic [9:0] got;
        capture(10'h15A, 15, 8'h00, 0, 10'h15A);
        tests++;
        if (done_a[13] !== 1'b1 || done_a[12] !== 1'b0) begin
            fails++;
            $display("FAIL wd_done k12=%b k13=%b want 0 1",
                     done_a[12], done_a[13]);
        end
        capture(10'h2A5, 15, 8'h00, 0, 10'h2A5);
        for (int k = 2; k <= 11; k++) got[11 - k] = mosi_a[k];
        tests++;
        if (got !== 10'h2A5) begin
            fails++;
            $display("FAIL ra_word got=%h want=2a5", got);
        end
        tests++;
        if (done_a[13] !== 1'b1 || rv_a[13] !== 1'b0) begin
            fails++;
            $display("FAIL ra_done done=%b rv=%b want 1 0",
                     done_a[13], rv_a[13]);
        end
    endtask

    task automatic test_read_data();
        int ss_bad;
        int rv_cnt;
        capture(10'h300, 26, 8'hC3, 0, 10'h300);
        tests++;
        if (rdd_a[23] !== 8'hC3) begin
            fails++;
            $display("FAIL rd_data got=%h want=c3", rdd_a[23]);
        end
        rv_cnt = 0;
        for (int k = 0; k < 26; k++) if (rv_a[k] === 1'b1) rv_cnt++;
        tests++;
        if (rv_a[23] !== 1'b1 || done_a[23] !== 1'b1 || rv_cnt != 1) begin
            fails++;
            $display("FAIL rd_pulse rv=%b done=%b cnt=%0d want 1 1 1",
                     rv_a[23], done_a[23], rv_cnt);
        end
        ss_bad = 0;
        for (int k = 0; k <= 22; k++) if (ss_a[k] !== 1'b0) ss_bad++;
        tests++;
        if (ss_bad != 0 || ss_a[23] !== 1'b1) begin
            fails++;
            $display("FAIL rd_ss high_in_frame=%0d k23=%b want 0 1",
                     ss_bad, ss_a[23]);
        end
        capture(10'h011, 15, 8'hFF, 0, 10'h011);
        tests++;
        if (rdd_a[14] !== 8'hC3 || rv_a[13] !== 1'b0) begin
            fails++;
            $display("FAIL rd_hold data=%h rv=%b want c3 0",
                     rdd_a[14], rv_a[13]);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] w1;
        logic [9:0] w2;
        int done_cnt;
        capture(10'h0A5, 30, 8'h00, 14, 10'h1FF);
        tests++;
        if (ss_a[13] !== 1'b1 || ss_a[14] !== 1'b0) begin
            fails++;
            $display("FAIL b2b_gap k13=%b k14=%b want 1 0",
                     ss_a[13], ss_a[14]);
        end
        for (int k = 2; k <= 11; k++) w1[11 - k] = mosi_a[k];
        for (int k = 16; k <= 25; k++) w2[25 - k] = mosi_a[k];
        tests++;
        if (w1 !== 10'h0A5 || w2 !== 10'h1FF) begin
            fails++;
            $display("FAIL b2b_words got=%h,%h want 0a5,1ff", w1, w2);
        end
        done_cnt = 0;
        for (int k = 0; k < 30; k++) if (done_a[k] === 1'b1) done_cnt++;
        tests++;
        if (done_a[13] !== 1'b1 || done_a[27] !== 1'b1 || done_cnt != 2) begin
            fails++;
            $display("FAIL b2b_done k13=%b k27=%b cnt=%0d want 1 1 2",
                     done_a[13], done_a[27], done_cnt);
        end
        tests++;
        if (ss_a[28] !== 1'b1 || ss_a[29] !== 1'b1) begin
            fails++;
            $display("FAIL b2b_stop k28=%b k29=%b want 1 1",
                     ss_a[28], ss_a[29]);
        end
    endtask

    task automatic test_reset_mid();
        int done_cnt;
        @(negedge clk);
        start = 1'b1;
        cmd_word = 10'h0A5;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        tests++;
        if ({SS_n, MOSI, busy, done} !== 4'b1000) begin
            fails++;
            $display("FAIL mid_reset got=%b want=1000",
                     {SS_n, MOSI, busy, done});
        end
        rst_n = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || SS_n !== 1'b1) done_cnt++;
        end
        tests++;
        if (done_cnt != 0) begin
            fails++;
            $display("FAIL mid_no_done events=%0d want=0", done_cnt);
        end
        capture(10'h0A5, 15, 8'h00, 0, 10'h0A5);
        tests++;
        if (done_a[13] !== 1'b1 || ss_a[0] !== 1'b0) begin
            fails++;
            $display("FAIL mid_recover done=%b ss0=%b want 1 0",
                     done_a[13], ss_a[0]);
        end
    endtask

    initial begin
        test_reset();
        test_seq_check();
        test_write_addr();
        test_write_rd_addr();
        test_read_data();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
